// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: cascade of registered main/skid stages; in_ready depends only on stage state
module pipe_stage_skid #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_DATA       = 2,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int CTRL_WIDTH     = 2,
    parameter int STAGES         = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [CTRL_WIDTH-1:0]              in_ctrl,
    input  logic [NUM_DATA*DATA_WIDTH-1:0]     in_data,
    input  logic [REG_ADDR_WIDTH-1:0]          in_waddr,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic [NUM_DATA*DATA_WIDTH-1:0]     out_data,
    output logic [REG_ADDR_WIDTH-1:0]          out_waddr,
    output logic [$clog2(2*STAGES+1)-1:0]      occupancy
);
    localparam int PW = CTRL_WIDTH + REG_ADDR_WIDTH + NUM_DATA * DATA_WIDTH;
    localparam int OW = $clog2(2 * STAGES + 1);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [PW-1:0]   pay [STAGES+1];
    logic [OW-1:0]   cnt [STAGES];
    logic [CTRL_WIDTH-1:0] ctrl_m;
    assign vld[0]      = in_valid;
    assign pay[0]      = {in_ctrl, in_waddr, in_data};
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        state_t        state, state_nx;
        logic [PW-1:0] main_q, skid_q;
        logic          in_x, out_x, v, r;
        assign in_x = vld[i] & rdy[i];
        assign out_x = vld[i+1] & rdy[i+1];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) state <= EMPTY;
            else state <= state_nx;
        end
        always_comb begin
            state_nx = flush ? EMPTY :
                       state == EMPTY ? (in_x ? FULL : EMPTY) :
                       state == FULL  ? (in_x && !out_x ? SKID : !in_x && out_x ? EMPTY : FULL) :
                       (out_x ? FULL : SKID);
        end
        always_comb begin
            v = state != EMPTY;
            r = state != SKID;
        end
        // killed beats never reach the payload registers, so outputs stay put after a flush
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                main_q <= '0;
                skid_q <= '0;
            end else if (!flush) begin
                if (in_x && (state == EMPTY || out_x)) main_q <= pay[i];
                else if (state == SKID && out_x) main_q <= skid_q;
                if (in_x && state == FULL && !out_x) skid_q <= pay[i];
            end
        end
        assign vld[i+1] = v;
        assign rdy[i]   = r;
        assign pay[i+1] = main_q;
        assign cnt[i]   = state == SKID ? OW'(2) : state == FULL ? OW'(1) : OW'(0);
    end
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) occupancy = occupancy + cnt[k];
    end
    assign out_valid = vld[STAGES];
    assign {ctrl_m, out_waddr, out_data} = pay[STAGES];
    assign out_ctrl = ctrl_m & {CTRL_WIDTH{out_valid}};
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomized checks on one to four cascaded stages
module tb_pipe_stage_skid;
    logic         clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [1:0]   in_ctrl = '0;
    logic [127:0] in_data = '0;
    logic [2:0]   in_waddr = '0;
    logic         ir [4], ov [4];
    logic [1:0]   oc [4];
    logic [127:0] od [4];
    logic [2:0]   ow [4];
    logic [3:0]   occ [4];
    int           cmp = 0, errs = 0;
    logic [132:0] q [$];
    logic [132:0] exp_p;
    logic         r0, ix, ox, took;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : u
        logic [$clog2(2*(g+1)+1)-1:0] o;
        pipe_stage_skid #(.STAGES(g + 1)) dut (
            .clk(clk), .reset_n(reset_n), .flush(flush),
            .in_valid(in_valid), .in_ready(ir[g]), .in_ctrl(in_ctrl),
            .in_data(in_data), .in_waddr(in_waddr),
            .out_valid(ov[g]), .out_ready(out_ready), .out_ctrl(oc[g]),
            .out_data(od[g]), .out_waddr(ow[g]), .occupancy(o)
        );
        assign occ[g] = 4'(o);
    end
    function automatic logic [127:0] mk(input logic [63:0] a, input logic [63:0] b);
        return {b, a};
    endfunction
    function automatic logic [127:0] beat(input int k);
        return mk(64'hA0 + 64'(k), 64'(k));
    endfunction
    task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [1:0] c, input logic [127:0] d, input logic [2:0] w);
        in_valid = v;
        in_ctrl = c;
        in_data = d;
        in_waddr = w;
    endtask
    task automatic rst_all;
        reset_n = 0;
        #1;
        reset_n = 1;
        #1;
    endtask
    initial begin
        #2;
        for (int g = 0; g < 4; g++) begin
            chk("rst_ready", 133'(ir[g]), 133'(1));
            chk("rst_valid", 133'(ov[g]), 133'(0));
            chk("rst_occ", 133'(occ[g]), 133'(0));
            chk("rst_data", 133'(od[g]), 133'(0));
        end
        @(negedge clk);
        reset_n = 1;
        out_ready = 1;
        drive(1, 2'b01, mk(64'h11, 64'h22), 3'd5);
        tick;
        chk("s1_valid", 133'(ov[0]), 133'(1));
        chk("s1_data", 133'(od[0]), 133'(mk(64'h11, 64'h22)));
        chk("s1_waddr", 133'(ow[0]), 133'(5));
        chk("s1_ctrl", 133'(oc[0]), 133'(1));
        chk("s1_occ", 133'(occ[0]), 133'(1));
        chk("s2_latency", 133'(ov[1]), 133'(0));
        drive(0, 2'b00, '0, 3'd0);
        tick;
        chk("s1_drained", 133'(ov[0]), 133'(0));
        chk("s1_occ0", 133'(occ[0]), 133'(0));
        chk("s1_ctrl_gated", 133'(oc[0]), 133'(0));
        chk("s1_data_hold", 133'(od[0]), 133'(mk(64'h11, 64'h22)));
        chk("s2_valid", 133'(ov[1]), 133'(1));
        chk("s2_data", 133'(od[1]), 133'(mk(64'h11, 64'h22)));
        out_ready = 0;
        rst_all;
        for (int k = 0; k < 5; k++) begin
            drive(1, 2'(k), beat(k), 3'(k));
            chk("fill_ready", 133'(ir[1]), 133'(k < 4));
            tick;
            if (k < 4) chk("fill_occ", 133'(occ[1]), 133'(k + 1));
        end
        chk("full_occ", 133'(occ[1]), 133'(4));
        chk("full_ready", 133'(ir[1]), 133'(0));
        chk("full_head", 133'(od[1]), 133'(beat(0)));
        out_ready = 1;
        for (int j = 0; j < 5; j++) begin
            chk("drain_valid", 133'(ov[1]), 133'(1));
            chk("drain_data", 133'(od[1]), 133'(beat(j)));
            chk("drain_waddr", 133'(ow[1]), 133'(j));
            took = in_valid & ir[1];
            tick;
            if (took) in_valid = 0;
        end
        chk("drain_empty", 133'(ov[1]), 133'(0));
        chk("drain_occ", 133'(occ[1]), 133'(0));
        out_ready = 0;
        drive(0, 2'b00, '0, 3'd0);
        rst_all;
        drive(1, 2'b11, mk(64'd1, 64'd2), 3'd1);
        tick;
        drive(1, 2'b10, mk(64'd3, 64'd4), 3'd2);
        out_ready = 1;
        chk("tog0_valid", 133'(ov[0]), 133'(1));
        chk("tog0_data", 133'(od[0]), 133'(mk(64'd1, 64'd2)));
        chk("tog0_ctrl", 133'(oc[0]), 133'(3));
        tick;
        in_valid = 0;
        out_ready = 0;
        chk("tog1_valid", 133'(ov[0]), 133'(1));
        chk("tog1_data", 133'(od[0]), 133'(mk(64'd3, 64'd4)));
        chk("tog1_ctrl", 133'(oc[0]), 133'(2));
        tick;
        out_ready = 1;
        chk("tog2_valid", 133'(ov[0]), 133'(1));
        chk("tog2_data", 133'(od[0]), 133'(mk(64'd3, 64'd4)));
        tick;
        out_ready = 0;
        chk("tog3_valid", 133'(ov[0]), 133'(0));
        chk("tog3_ctrl", 133'(oc[0]), 133'(0));
        chk("tog3_hold", 133'(od[0]), 133'(mk(64'd3, 64'd4)));
        chk("tog3_occ", 133'(occ[0]), 133'(0));
        tick;
        chk("tog4_valid", 133'(ov[0]), 133'(0));
        rst_all;
        for (int k = 0; k < 3; k++) begin
            drive(1, 2'b01, beat(k), 3'(k));
            tick;
        end
        chk("pre_flush_occ", 133'(occ[2]), 133'(3));
        chk("pre_flush_valid", 133'(ov[2]), 133'(1));
        chk("pre_flush_head", 133'(od[2]), 133'(beat(0)));
        drive(1, 2'b01, beat(3), 3'd3);
        flush = 1;
        tick;
        flush = 0;
        drive(0, 2'b00, '0, 3'd0);
        chk("flush_occ", 133'(occ[2]), 133'(0));
        chk("flush_valid", 133'(ov[2]), 133'(0));
        chk("flush_ready", 133'(ir[2]), 133'(1));
        tick;
        chk("flush_discard", 133'(ov[2]), 133'(0));
        chk("flush_occ2", 133'(occ[2]), 133'(0));
        rst_all;
        drive(1, 2'b01, beat(0), 3'd0);
        tick;
        drive(1, 2'b10, beat(1), 3'd1);
        tick;
        drive(0, 2'b00, '0, 3'd0);
        chk("skid_occ", 133'(occ[0]), 133'(2));
        chk("skid_ready", 133'(ir[0]), 133'(0));
        chk("skid_ctrl", 133'(oc[0]), 133'(1));
        reset_n = 0;
        #1;
        chk("arst_valid", 133'(ov[0]), 133'(0));
        chk("arst_ctrl", 133'(oc[0]), 133'(0));
        chk("arst_occ", 133'(occ[0]), 133'(0));
        chk("arst_data", 133'(od[0]), 133'(0));
        chk("arst_ready", 133'(ir[0]), 133'(1));
        reset_n = 1;
        out_ready = 1;
        drive(1, 2'b01, mk(64'd5, 64'd6), 3'd7);
        tick;
        drive(0, 2'b00, '0, 3'd0);
        chk("post_rst_valid", 133'(ov[0]), 133'(1));
        chk("post_rst_data", 133'(od[0]), 133'(mk(64'd5, 64'd6)));
        chk("post_rst_waddr", 133'(ow[0]), 133'(7));
        tick;
        chk("post_rst_empty", 133'(ov[0]), 133'(0));
        rst_all;
        q.delete();
        for (int n = 0; n < 10000; n++) begin
            chk("rnd_occ", 133'(occ[3]), 133'(q.size()));
            drive(1'($urandom_range(0, 1)), 2'($urandom), {$urandom, $urandom, $urandom, $urandom}, 3'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            r0 = ir[3];
            out_ready = ~out_ready;
            #1;
            chk("comb_path", 133'(ir[3]), 133'(r0));
            out_ready = ~out_ready;
            #1;
            ix = in_valid & ir[3];
            ox = ov[3] & out_ready;
            if (!ov[3]) chk("rnd_ctrl_gate", 133'(oc[3]), 133'(0));
            if (ox) begin
                exp_p = q.size() > 0 ? q.pop_front() : 'x;
                chk("rnd_order", {oc[3], ow[3], od[3]}, exp_p);
            end
            if (ix) q.push_back({in_ctrl, in_waddr, in_data});
            tick;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 64, width of one data lane
- NUM_DATA, 2, number of data lanes (r1/r2 operands)
- REG_ADDR_WIDTH, 3, destination register address width
- CTRL_WIDTH, 2, control bits (bit0 w_reg_en, bit1 w_mem_en)
- STAGES, 1, number of cascaded register stages, legal range 1..8
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state updates on its rising edge
- reset_n, in, 1, asynchronous active-low reset
- flush, in, 1, synchronous pipeline kill
- in_valid, in, 1, upstream beat present
- in_ready, out, 1, block accepts a beat this cycle
- in_ctrl, in, CTRL_WIDTH, control bits of the beat
- in_data, in, NUM_DATA*DATA_WIDTH, data lanes, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- in_waddr, in, REG_ADDR_WIDTH, destination register address
- out_valid, out, 1, downstream beat present
- out_ready, in, 1, downstream accepts
- out_ctrl, out, CTRL_WIDTH, control bits, gated by out_valid
- out_data, out, NUM_DATA*DATA_WIDTH, data lanes
- out_waddr, out, REG_ADDR_WIDTH, destination address
- occupancy, out, $clog2(2*STAGES+1), beats currently held

Function
REQ-003 A transfer SHALL occur on an edge where valid and ready are both high on the same side; otherwise no beat SHALL be consumed or produced.
REQ-004 Each stage SHALL hold one main register and one skid register (payload = ctrl, data, waddr) and SHALL have the states EMPTY, FULL and SKID.
REQ-005 Stage transitions: EMPTY + in xfer -> FULL (load main); FULL + in xfer + out xfer -> FULL (load main); FULL + in xfer only -> SKID (load skid); FULL + out xfer only -> EMPTY; SKID + out xfer -> FULL (main <= skid); otherwise hold.
REQ-006 Stage ready SHALL be (state != SKID) and SHALL be a function of registers only, with no combinational path from out_ready to in_ready.
REQ-007 Stage valid SHALL be (state != EMPTY); stage output payload SHALL be the main register.
REQ-008 Stage i output SHALL drive stage i+1 input; stage 0 input SHALL be the block input; stage STAGES-1 output SHALL be the block output.
REQ-009 With out_ready held high, latency SHALL be exactly STAGES cycles from the in transfer to out_valid, and throughput SHALL be one beat per cycle.
REQ-010 Beats SHALL leave in arrival order with no loss or duplication under any valid/ready pattern.
REQ-011 out_ctrl SHALL equal main ctrl AND out_valid, so write enables are never asserted on an invalid beat.
REQ-012 A payload register SHALL change only when it is loaded; when out_valid is 0, out_data and out_waddr SHALL hold their last values.
REQ-013 occupancy SHALL be the sum of all valid main and skid entries:
- +1 on an in transfer, -1 on an out transfer, unchanged when both occur
- maximum 2*STAGES, at which point in_ready = 0
REQ-014 When flush = 1 at an edge, every stage SHALL go to EMPTY and occupancy SHALL go to 0, regardless of valid/ready.
REQ-015 During a flush edge, an in transfer SHALL be discarded and the out transfer SHALL complete if out_valid and out_ready were both high.
REQ-016 When flush = 1, payload registers need not be cleared.
REQ-017 Under flush, in_ready SHALL still follow REQ-006.

Reset
REQ-018 While reset_n = 0, asynchronously:
- all stages EMPTY
- all payload registers 0
- out_valid = 0, out_ctrl = 0, out_data = 0, out_waddr = 0
- occupancy = 0, in_ready = 1
REQ-019 The first in transfer SHALL be possible on the first rising clk edge after reset_n rises.
REQ-020 Reset asserted mid-operation SHALL drop all held beats with no partial output.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- STAGES=1, out_ready=1, in_data lanes {0x11, 0x22}, waddr 5, ctrl 2'b01 -> next cycle out_valid=1, out_data {0x11, 0x22}, out_waddr=5, out_ctrl=2'b01, occupancy=0 after the out transfer.
- STAGES=2, out_ready=0, drive beats A, B, C, D, E -> A..D accepted, in_ready=0 at occupancy=4, E held upstream. Then out_ready=1 -> A, B, C, D, E emerge in order, one per cycle.
- STAGES=1, FULL with A, in_valid with B, out_ready toggling 1,0,1,0 -> no loss or duplicate. out_ctrl=0 whenever out_valid=0.
- STAGES=3, three beats in flight, flush with in_valid=1 on the same edge -> occupancy=0 and out_valid=0 next cycle, input beat discarded, in_ready=1.
- Occupancy=2 in STAGES=1, reset_n pulled low between edges -> out_valid, out_ctrl and occupancy go to 0 immediately, out_data=0. After release, a new beat passes with 1-cycle latency.
- Random valid/ready on both sides for 10,000 cycles, STAGES=4 -> scoreboard order matches, occupancy equals the model, no combinational out_ready->in_ready path found.
